// File: rtl/pipeline_muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_muldiv_unit_if
// Brief   : Issue/result bundle between the EX stage and the mul/div unit.
// Revision: 1.0 - initial release
// ============================================================================
interface pipeline_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             rd_hilo;
    logic             flush;
    logic             busy;
    logic             stall_req;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, operand_a, operand_b, rd_hilo, flush,
        input  busy, stall_req, done, hi, lo
    );

    modport slave (
        input  start, op, operand_a, operand_b, rd_hilo, flush,
        output busy, stall_req, done, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_muldiv_unit
// Brief   : Bit-serial MULT/MULTU/DIV/DIVU into private HI/LO, with pipeline stall.
// Revision: 1.0 - initial release
// ============================================================================
module pipeline_muldiv_unit #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] HILO_RESET = '0
) (
    input  wire logic             clock,
    input  wire logic             reset,
    pipeline_muldiv_unit_if.slave bus
);
    localparam int               c_CW   = $clog2(WIDTH + 1);
    localparam logic [c_CW-1:0]  c_LAST = c_CW'(WIDTH - 1);
    localparam logic [c_CW-1:0]  c_ONE  = c_CW'(1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_FIX  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [c_CW-1:0]  r_count;

    // Shared datapath: r_acc/r_work form the running {hi,lo} pair,
    // r_mcand is the multiplicand (multiply) or divisor (divide) magnitude.
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_mcand;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_div_zero;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;

    logic             w_busy;
    logic             w_accept;
    logic             w_step;
    logic             w_commit;
    logic             w_stall;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

    logic [WIDTH:0]   w_msum;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;
    logic [WIDTH-1:0] w_step_acc;
    logic [WIDTH-1:0] w_step_work;

    logic [2*WIDTH-1:0] w_prod_mag;
    logic [2*WIDTH-1:0] w_prod_res;
    logic [WIDTH-1:0]   w_quot_res;
    logic [WIDTH-1:0]   w_rem_res;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM: next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: if (bus.start && !bus.flush) w_next = c_ST_RUN;
            c_ST_RUN: begin
                if (bus.flush)             w_next = c_ST_IDLE;
                else if (r_count == c_LAST) w_next = c_ST_FIX;
            end
            c_ST_FIX:  w_next = c_ST_IDLE;
            default:   w_next = c_ST_IDLE;
        endcase
    end

    // FSM: decoded controls
    always_comb begin
        w_busy   = (r_state != c_ST_IDLE);
        w_accept = (r_state == c_ST_IDLE) && bus.start && !bus.flush;
        w_step   = (r_state == c_ST_RUN) && !bus.flush;
        w_commit = (r_state == c_ST_FIX) && !bus.flush;
        w_stall  = w_busy && (bus.start || bus.rd_hilo);
    end

    // ------------------------------------------------------------------
    // Operand magnitudes and per-step arithmetic
    // ------------------------------------------------------------------
    always_comb begin
        w_a_neg = bus.op[0] && bus.operand_a[WIDTH-1];
        w_b_neg = bus.op[0] && bus.operand_b[WIDTH-1];
        w_a_mag = w_a_neg ? -bus.operand_a : bus.operand_a;
        w_b_mag = w_b_neg ? -bus.operand_b : bus.operand_b;
    end

    always_comb begin
        w_msum  = r_work[0] ? ({1'b0, r_acc} + {1'b0, r_mcand}) : {1'b0, r_acc};
        // Restoring divide: the partial remainder never reaches 2^WIDTH
        // once stored, so only the shifted value needs the extra bit.
        w_shift = {r_acc, r_work[WIDTH-1]};
        w_ge    = (w_shift >= {1'b0, r_mcand});
        w_sub   = w_shift[WIDTH-1:0] - r_mcand;
        if (r_is_div) begin
            w_step_acc  = w_ge ? w_sub : w_shift[WIDTH-1:0];
            w_step_work = {r_work[WIDTH-2:0], w_ge};
        end else begin
            w_step_acc  = w_msum[WIDTH:1];
            w_step_work = {w_msum[0], r_work[WIDTH-1:1]};
        end
    end

    // Sign correction; a zero divisor leaves the all-ones quotient untouched
    // while the remainder path regenerates the dividend as issued.
    always_comb begin
        w_prod_mag = {r_acc, r_work};
        w_prod_res = r_neg_q ? -w_prod_mag : w_prod_mag;
        w_quot_res = (r_neg_q && !r_div_zero) ? -r_work : r_work;
        w_rem_res  = r_neg_r ? -r_acc : r_acc;
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count    <= '0;
            r_acc      <= '0;
            r_work     <= '0;
            r_mcand    <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= HILO_RESET;
            r_lo       <= HILO_RESET;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_commit;
            if (w_accept) begin
                r_count    <= '0;
                r_acc      <= '0;
                r_is_div   <= bus.op[1];
                r_neg_q    <= w_a_neg ^ w_b_neg;
                r_neg_r    <= w_a_neg;
                r_div_zero <= (bus.operand_b == '0);
                r_work     <= bus.op[1] ? w_a_mag : w_b_mag;
                r_mcand    <= bus.op[1] ? w_b_mag : w_a_mag;
            end else if (w_step) begin
                r_count <= r_count + c_ONE;
                r_acc   <= w_step_acc;
                r_work  <= w_step_work;
            end
            if (w_commit) begin
                if (r_is_div) begin
                    r_hi <= w_rem_res;
                    r_lo <= w_quot_res;
                end else begin
                    r_hi <= w_prod_res[2*WIDTH-1:WIDTH];
                    r_lo <= w_prod_res[WIDTH-1:0];
                end
            end
        end
    end

    assign bus.busy      = w_busy;
    assign bus.stall_req = w_stall;
    assign bus.done      = r_done;
    assign bus.hi        = r_hi;
    assign bus.lo        = r_lo;
endmodule
`default_nettype wire

// File: tb/tb_pipeline_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipeline_muldiv_unit
// Brief   : Scoreboard bench for pipeline_muldiv_unit (WIDTH=32).
// Revision: 1.0 - initial release
// ============================================================================
module tb_pipeline_muldiv_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_muldiv_unit_if #(.WIDTH(W)) bus();

    pipeline_muldiv_unit #(.WIDTH(W), .HILO_RESET(32'h0)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_done   = 0;
    logic [63:0] sb_q[$];
    logic [63:0] mon_exp;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Reference model returning {hi, lo}
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] pa, pb;
        logic signed [31:0] sa, sb;
        logic [31:0]        q, r;
        sa = a;
        sb = b;
        case (op)
            2'b00: model = {32'h0, a} * {32'h0, b};
            2'b01: begin
                pa = {{32{a[31]}}, a};
                pb = {{32{b[31]}}, b};
                model = pa * pb;
            end
            2'b10: model = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: begin
                if (b == 0) model = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = {32'h0, 32'h8000_0000};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    model = {r, q};
                end
            end
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            n_done++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_exp = sb_q.pop_front();
                check("hi", {32'h0, bus.hi}, {32'h0, mon_exp[63:32]});
                check("lo", {32'h0, bus.lo}, {32'h0, mon_exp[31:0]});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start     = 1'b1;
        bus.op        = op;
        bus.operand_a = a;
        bus.operand_b = b;
        step();
        bus.start = 1'b0;
    endtask

    // Waits for done; lat = posedges from the accept edge to the done cycle
    task automatic wait_done(input string tag, output int lat, output int busy_cyc);
        lat      = -1;
        busy_cyc = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (bus.busy === 1'b1) busy_cyc++;
            if (bus.done === 1'b1) begin
                lat = k - 1;
                return;
            end
        end
        check({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
        int lat, bc;
        sb_q.push_back(exp);
        issue(op, a, b);
        wait_done(tag, lat, bc);
        step();
        check({tag, "_done_pulse"}, {63'h0, bus.done}, 64'd0);
    endtask

    initial begin
        int          lat, bc, stall_bad, saved_done;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.op        = 2'b00;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.rd_hilo   = 1'b0;
        bus.flush     = 1'b0;
        repeat (3) step();
        check("rst_busy",  {63'h0, bus.busy}, 64'd0);
        check("rst_done",  {63'h0, bus.done}, 64'd0);
        check("rst_hilo",  {bus.hi, bus.lo}, 64'd0);
        rst = 1'b0;
        step();

        // Full-range MULTU with latency/busy-length checks
        sb_q.push_back({32'hFFFF_FFFE, 32'h0000_0001});
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu_max", lat, bc);
        check("multu_latency", lat, 64'd33);
        check("multu_busy_cycles", bc, 64'd33);
        step();

        run_op("mult_neg",  2'b01, 32'hFFFF_FFFD, 32'd7,        {32'hFFFF_FFFF, 32'hFFFF_FFEB});
        run_op("div_neg",   2'b11, 32'hFFFF_FFF9, 32'd2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op("divu_zero", 2'b10, 32'd5,         32'd0,        {32'h0000_0005, 32'hFFFF_FFFF});
        run_op("div_ovf",   2'b11, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});

        bus.rd_hilo = 1'b1;
        #1;
        check("idle_rd_hilo_no_stall", {63'h0, bus.stall_req}, 64'd0);
        bus.rd_hilo = 1'b0;

        // Back-to-back issue with MFHI pending: held until busy falls
        sb_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFC4});
        issue(2'b01, 32'd12, 32'hFFFF_FFFB);
        repeat (4) step();
        sb_q.push_back({32'h0000_0001, 32'h0000_0000});
        bus.start     = 1'b1;
        bus.op        = 2'b00;
        bus.operand_a = 32'h0001_0000;
        bus.operand_b = 32'h0001_0000;
        bus.rd_hilo   = 1'b1;
        stall_bad     = 0;
        lat           = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
            if (bus.busy !== 1'b1 || bus.stall_req !== 1'b1) stall_bad++;
        end
        check("stall_held", stall_bad, 64'd0);
        check("stall_reached_done", {63'h0, (lat >= 0)}, 64'd1);
        check("done_cycle_no_stall", {63'h0, bus.stall_req}, 64'd0);
        step();
        bus.start   = 1'b0;
        bus.rd_hilo = 1'b0;
        check("second_accepted", {63'h0, bus.busy}, 64'd1);
        wait_done("second_op", lat, bc);
        check("second_latency", lat, 64'd33);
        step();

        // Flush mid-divide
        saved_done = n_done;
        issue(2'b10, 32'd100, 32'd7);
        repeat (9) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("flush_busy", {63'h0, bus.busy}, 64'd0);
        repeat (40) step();
        check("flush_no_done", n_done, saved_done);
        check("flush_hilo_kept", {bus.hi, bus.lo}, {32'h1, 32'h0});

        bus.start = 1'b1;
        bus.flush = 1'b1;
        step();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("start_flush_dropped", {63'h0, bus.busy}, 64'd0);

        // Reset mid-multiply
        issue(2'b01, 32'd7, 32'd9);
        repeat (19) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
        check("midrst_busy", {63'h0, bus.busy}, 64'd0);
        check("midrst_done", {63'h0, bus.done}, 64'd0);
        run_op("after_rst", 2'b10, 32'd100, 32'd7, {32'd2, 32'd14});

        for (int i = 0; i < 12; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i % 5 == 0) ? 32'h0 : ($urandom >> $urandom_range(0, 31));
            if (i % 3 == 0) rb = -rb;
            run_op("rand", rop, ra, rb, model(rop, ra, rb));
        end

        repeat (3) step();
        check("scoreboard_empty", sb_q.size(), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
